// File: rtl/cpu_pkg.sv
// Shared fetch-side constants, derived field widths and
// the instruction cache state encoding.
package cpu_pkg;

   localparam int SIZE    = 32;
   localparam int LINES   = 16;
   localparam int WORDS   = 4;
   localparam int WORD_W  = $clog2(WORDS);
   localparam int INDEX_W = $clog2(LINES);
   localparam int TAG_W   = SIZE - INDEX_W - WORD_W - 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/instruction_cache_array.sv
// Direct-mapped tag/valid/data storage: one async read port,
// one word write port, one line commit port and a bulk valid clear.
module instruction_cache_array #(
   parameter int SIZE    = cpu_pkg::SIZE,
   parameter int LINES   = cpu_pkg::LINES,
   parameter int INDEX_W = cpu_pkg::INDEX_W,
   parameter int WORD_W  = cpu_pkg::WORD_W,
   parameter int TAG_W   = cpu_pkg::TAG_W
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               clear,
   input  logic [INDEX_W-1:0] rdIndex,
   input  logic [WORD_W-1:0]  rdWord,
   output logic               rdValid,
   output logic [TAG_W-1:0]   rdTag,
   output logic [SIZE-1:0]    rdData,
   input  logic               wrData,
   input  logic [INDEX_W-1:0] wrIndex,
   input  logic [WORD_W-1:0]  wrWord,
   input  logic [SIZE-1:0]    wrWordData,
   input  logic               wrLine,
   input  logic [TAG_W-1:0]   wrTag
);

   localparam int DEPTH = LINES << WORD_W;

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];
   logic [SIZE-1:0]  data [DEPTH];

   assign rdValid = valid[rdIndex];
   assign rdTag   = tags[rdIndex];
   assign rdData  = data[{rdIndex, rdWord}];

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         valid <= '0;
      end else if (clear) begin
         valid <= '0;
      end else if (wrLine) begin
         valid[wrIndex] <= 1'b1;
      end
   end

   // Tag and data contents are only meaningful behind a set valid bit
   always_ff @(posedge clk) begin
      if (wrData) begin
         data[{wrIndex, wrWord}] <= wrWordData;
      end
      if (wrLine) begin
         tags[wrIndex] <= wrTag;
      end
   end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with a beat-wise line refill
// engine (IDLE -> FILL -> DONE) and whole-cache flush.
module instruction_cache #(
   parameter int SIZE  = cpu_pkg::SIZE,
   parameter int LINES = cpu_pkg::LINES,
   parameter int WORDS = cpu_pkg::WORDS
) (
   input  logic            clk,
   input  logic            rstN,
   input  logic [SIZE-1:0] pc,
   input  logic            flush,
   output logic            hit,
   output logic [SIZE-1:0] instruction,
   output logic [SIZE-1:0] nextPC,
   output logic            memReq,
   output logic [SIZE-1:0] memAddr,
   input  logic            memReady,
   input  logic [SIZE-1:0] memData
);

   import cpu_pkg::*;

   localparam int WB = $clog2(WORDS);
   localparam int IB = $clog2(LINES);
   localparam int TB = SIZE - IB - WB - 2;
   localparam logic [SIZE-1:0] LMASK = ~SIZE'(WORDS * 4 - 1);

   state_t          state;
   state_t          state_n;
   logic [WB-1:0]   beat;
   logic [SIZE-1:0] missAddr;

   logic [WB-1:0]   word;
   logic [IB-1:0]   index;
   logic [TB-1:0]   tag;
   logic            rdValid;
   logic [TB-1:0]   rdTag;
   logic [SIZE-1:0] rdData;
   logic            lookup;
   logic            fill;
   logic            accept;
   logic            last;
   logic            lineDone;
   logic            missStart;
   logic            unused_pc;

   assign word      = pc[WB+1:2];
   assign index     = pc[WB+IB+1:WB+2];
   assign tag       = pc[SIZE-1:SIZE-TB];
   assign unused_pc = ^pc[1:0];

   assign lookup      = rdValid && (rdTag == tag);
   assign hit         = (state == IDLE) && lookup && !flush;
   assign instruction = hit ? rdData : '0;
   assign nextPC      = pc + SIZE'(4);

   assign fill    = (state == FILL);
   assign memReq  = fill;
   assign memAddr = missAddr + SIZE'({beat, 2'b00});
   assign accept  = fill && memReady;
   assign last    = (beat == WB'(WORDS - 1));
   // Flush wins over the final beat, so the line stays invalid
   assign lineDone = accept && last && !flush;

   always_comb begin
      state_n   = state;
      missStart = 1'b0;
      unique case (state)
         IDLE: begin
            if (!flush && !lookup) begin
               state_n   = FILL;
               missStart = 1'b1;
            end
         end
         FILL: begin
            if (flush) begin
               state_n = IDLE;
            end else if (accept && last) begin
               state_n = DONE;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state    <= IDLE;
         beat     <= '0;
         missAddr <= '0;
      end else begin
         state <= state_n;
         if (missStart) begin
            missAddr <= pc & LMASK;
            beat     <= '0;
         end else if (accept && !flush) begin
            beat <= beat + 1'b1;
         end
      end
   end

   instruction_cache_array #(
      .SIZE    (SIZE),
      .LINES   (LINES),
      .INDEX_W (IB),
      .WORD_W  (WB),
      .TAG_W   (TB)
   ) u_array (
      .clk        (clk),
      .rstN       (rstN),
      .clear      (flush),
      .rdIndex    (index),
      .rdWord     (word),
      .rdValid    (rdValid),
      .rdTag      (rdTag),
      .rdData     (rdData),
      .wrData     (accept),
      .wrIndex    (missAddr[WB+IB+1:WB+2]),
      .wrWord     (beat),
      .wrWordData (memData),
      .wrLine     (lineDone),
      .wrTag      (missAddr[SIZE-1:SIZE-TB])
   );

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: per-cycle vector table
// plus hand sequences for flush and reset corner cases.
module tb_instruction_cache;

   logic        clk = 1'b0;
   logic        rstN;
   logic [31:0] pc;
   logic        flush;
   logic        hit;
   logic [31:0] instruction;
   logic [31:0] nextPC;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memReady;
   logic [31:0] memData;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [31:0] pc;
      logic        flush;
      logic        rdy;
      logic        hit;
      logic [31:0] instr;
      logic        req;
      logic [31:0] addr;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   instruction_cache dut (
      .clk         (clk),
      .rstN        (rstN),
      .pc          (pc),
      .flush       (flush),
      .hit         (hit),
      .instruction (instruction),
      .nextPC      (nextPC),
      .memReq      (memReq),
      .memAddr     (memAddr),
      .memReady    (memReady),
      .memData     (memData)
   );

   function automatic logic [31:0] mw(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   assign memData = mw(memAddr);

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [31:0] p, input logic f,
                      input logic r, input logic h,
                      input logic [31:0] ins, input logic q,
                      input logic [31:0] a);
      vec_t v;
      v.pc = p; v.flush = f; v.rdy = r; v.hit = h;
      v.instr = ins; v.req = q; v.addr = a;
      vq.push_back(v);
   endtask

   initial begin
      // cold fill of line 0x00
      add(32'h0, 0, 1, 0, 0, 0, 0);
      add(32'h0, 0, 1, 0, 0, 1, 32'h0);
      add(32'h0, 0, 1, 0, 0, 1, 32'h4);
      add(32'h0, 0, 1, 0, 0, 1, 32'h8);
      add(32'h0, 0, 1, 0, 0, 1, 32'hC);
      add(32'h0, 0, 1, 0, 0, 0, 0);
      add(32'h0, 0, 1, 1, mw(32'h0), 0, 0);
      add(32'h8, 0, 1, 1, mw(32'h8), 0, 0);
      add(32'h4, 0, 1, 1, mw(32'h4), 0, 0);
      // conflict miss at same index
      add(32'h100, 0, 1, 0, 0, 0, 0);
      add(32'h100, 0, 1, 0, 0, 1, 32'h100);
      add(32'h100, 0, 1, 0, 0, 1, 32'h104);
      add(32'h100, 0, 1, 0, 0, 1, 32'h108);
      add(32'h100, 0, 1, 0, 0, 1, 32'h10C);
      add(32'h100, 0, 1, 0, 0, 0, 0);
      add(32'h100, 0, 1, 1, mw(32'h100), 0, 0);
      add(32'h0, 0, 1, 0, 0, 0, 0);
      add(32'h0, 0, 1, 0, 0, 1, 32'h0);
      add(32'h0, 0, 1, 0, 0, 1, 32'h4);
      add(32'h0, 0, 1, 0, 0, 1, 32'h8);
      add(32'h0, 0, 1, 0, 0, 1, 32'hC);
      add(32'h0, 0, 1, 0, 0, 0, 0);
      add(32'h0, 0, 1, 1, mw(32'h0), 0, 0);
      // stalled refill, pc wanders mid-fill
      add(32'h10, 0, 1, 0, 0, 0, 0);
      add(32'h10, 0, 1, 0, 0, 1, 32'h10);
      add(32'h10, 0, 0, 0, 0, 1, 32'h14);
      add(32'h10, 0, 0, 0, 0, 1, 32'h14);
      add(32'h10, 0, 0, 0, 0, 1, 32'h14);
      add(32'h10, 0, 1, 0, 0, 1, 32'h14);
      add(32'hABC0, 0, 1, 0, 0, 1, 32'h18);
      add(32'hABC0, 0, 1, 0, 0, 1, 32'h1C);
      add(32'hABC0, 0, 1, 0, 0, 0, 0);
      add(32'h14, 0, 1, 1, mw(32'h14), 0, 0);
      add(32'h18, 0, 1, 1, mw(32'h18), 0, 0);
      add(32'hFFFFFFFC, 0, 1, 0, 0, 0, 0);

      rstN = 1'b0;
      pc = 32'h0;
      flush = 1'b0;
      memReady = 1'b1;
      tick;
      tick;
      chk("rst hit", {31'b0, hit}, 0);
      chk("rst instr", instruction, 0);
      chk("rst req", {31'b0, memReq}, 0);
      chk("rst addr", memAddr, 0);
      rstN = 1'b1;

      foreach (vq[i]) begin
         pc = vq[i].pc;
         flush = vq[i].flush;
         memReady = vq[i].rdy;
         #1;
         chk($sformatf("v%0d hit", i), {31'b0, hit}, {31'b0, vq[i].hit});
         chk($sformatf("v%0d instr", i), instruction, vq[i].instr);
         chk($sformatf("v%0d req", i), {31'b0, memReq}, {31'b0, vq[i].req});
         chk($sformatf("v%0d next", i), nextPC, vq[i].pc + 32'd4);
         if (vq[i].req) chk($sformatf("v%0d addr", i), memAddr, vq[i].addr);
         tick;
      end

      // flush on the final beat of the 0xFFFFFFF0 refill
      chk("fl b0", memAddr, 32'hFFFFFFF0);
      tick;
      chk("fl b1", memAddr, 32'hFFFFFFF4);
      tick;
      chk("fl b2", memAddr, 32'hFFFFFFF8);
      tick;
      flush = 1'b1;
      #1;
      chk("fl b3 addr", memAddr, 32'hFFFFFFFC);
      chk("fl b3 req", {31'b0, memReq}, 1);
      chk("fl b3 hit", {31'b0, hit}, 0);
      tick;
      flush = 1'b0;
      #1;
      chk("fl idle req", {31'b0, memReq}, 0);
      chk("fl idle hit", {31'b0, hit}, 0);
      tick;
      chk("fl refetch req", {31'b0, memReq}, 1);
      chk("fl refetch addr", memAddr, 32'hFFFFFFF0);
      tick;
      tick;
      tick;
      tick;
      chk("fl done hit", {31'b0, hit}, 0);
      tick;
      chk("fl refill hit", {31'b0, hit}, 1);
      chk("fl refill instr", instruction, mw(32'hFFFFFFFC));
      pc = 32'h0;
      #1;
      chk("fl line0 gone", {31'b0, hit}, 0);

      // flush while idle on a valid line
      pc = 32'hFFFFFFFC;
      flush = 1'b1;
      #1;
      chk("fi hit", {31'b0, hit}, 0);
      tick;
      flush = 1'b0;
      #1;
      chk("fi cleared", {31'b0, hit}, 0);
      chk("fi req", {31'b0, memReq}, 0);
      tick;
      chk("rm req", {31'b0, memReq}, 1);

      // reset in the middle of a fill
      rstN = 1'b0;
      #1;
      chk("rm req0", {31'b0, memReq}, 0);
      chk("rm hit0", {31'b0, hit}, 0);
      chk("rm addr0", memAddr, 0);
      chk("rm instr0", instruction, 0);
      tick;
      rstN = 1'b1;
      #1;
      chk("rm post hit", {31'b0, hit}, 0);
      chk("rm post req", {31'b0, memReq}, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
